// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Pipelined carry-lookahead adder/subtractor. The N-bit operands are cut into
// BLOCK-bit slices and each pipeline stage adds one slice, least significant
// first. Inside a slice, carries come from 4-bit lookahead groups, and only the
// group carries ripple from one group to the next. The slice carry is
// registered into the next stage. Upper operand slices that have not been added
// yet travel along with the beat. Lower sum slices that are already finished
// travel forward with it too.
//
// When the output is valid and not accepted, the whole pipeline stalls.
// Bubbles are not squeezed out.
//
// Optional feature macro: PIPE_ADDER_OVF_EN
//   defined     -> ovf is the signed overflow of the sum, registered with the beat
//   not defined -> ovf is tied to 0 and no overflow logic is built
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle
//   a, b       operands (N bits)
//   cin        carry-in (ignored when sub=1)
//   sub        1: result = a - b
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   result     {carry_out, sum} (N+1 bits)
//   ovf        signed overflow of sum
// -----------------------------------------------------------------------------
module pipelined_cla_adder #(
   parameter int N     = 32,
   parameter int BLOCK = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N:0]   result,
   output logic         ovf
);

   localparam int STAGES = N / BLOCK;
   localparam int GROUPS = BLOCK / 4;

   // Per-stage pipeline state. Stage k holds the operands, the sum bits
   // completed so far, the carry out of slice k, and a valid bit.
   logic [N-1:0]        a_reg   [STAGES];
   logic [N-1:0]        b_reg   [STAGES];
   logic [N-1:0]        sum_reg [STAGES];
   logic [STAGES-1:0]   c_reg;
   logic [STAGES-1:0]   v_reg;

   logic [N-1:0]        a_next   [STAGES];
   logic [N-1:0]        b_next   [STAGES];
   logic [N-1:0]        sum_next [STAGES];
   logic [STAGES-1:0]   c_next;
   logic [STAGES-1:0]   v_next;

   logic                advance;

   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign out_valid = v_reg[STAGES-1];
   assign result    = {c_reg[STAGES-1], sum_reg[STAGES-1]};

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [N-1:0]     src_a;
         logic [N-1:0]     src_b;
         logic [N-1:0]     src_sum;
         logic             src_c;
         logic             src_v;
         logic [BLOCK-1:0] sa;
         logic [BLOCK-1:0] sb;
         logic [BLOCK-1:0] g;
         logic [BLOCK-1:0] p;
         logic [BLOCK:0]   cv;
         logic [N-1:0]     sum_merged;

         if (gi == 0) begin : g_first
            // Subtraction is a + ~b + 1. It is folded in at the pipeline
            // entry, so every later stage only ever adds.
            assign src_a   = a;
            assign src_b   = sub ? ~b : b;
            assign src_c   = sub ? 1'b1 : cin;
            assign src_sum = '0;
            assign src_v   = in_valid;
         end else begin : g_rest
            assign src_a   = a_reg[gi-1];
            assign src_b   = b_reg[gi-1];
            assign src_c   = c_reg[gi-1];
            assign src_sum = sum_reg[gi-1];
            assign src_v   = v_reg[gi-1];
         end

         assign sa    = src_a[gi*BLOCK +: BLOCK];
         assign sb    = src_b[gi*BLOCK +: BLOCK];
         assign g     = sa & sb;
         assign p     = sa ^ sb;
         assign cv[0] = src_c;

         // Each group computes its internal carries from its own carry-in
         // only, using two-level lookahead. cv[4*gj] is the carry passed
         // from one group to the next.
         for (genvar gj = 0; gj < GROUPS; gj++) begin : g_group
            localparam int B = gj * 4;
            assign cv[B+1] = g[B]
                           | (p[B] & cv[B]);
            assign cv[B+2] = g[B+1]
                           | (p[B+1] & g[B])
                           | (p[B+1] & p[B] & cv[B]);
            assign cv[B+3] = g[B+2]
                           | (p[B+2] & g[B+1])
                           | (p[B+2] & p[B+1] & g[B])
                           | (p[B+2] & p[B+1] & p[B] & cv[B]);
            assign cv[B+4] = g[B+3]
                           | (p[B+3] & g[B+2])
                           | (p[B+3] & p[B+2] & g[B+1])
                           | (p[B+3] & p[B+2] & p[B+1] & g[B])
                           | (p[B+3] & p[B+2] & p[B+1] & p[B] & cv[B]);
         end

         always_comb begin
            sum_merged = src_sum;
            sum_merged[gi*BLOCK +: BLOCK] = p ^ cv[BLOCK-1:0];
         end

         assign a_next[gi]   = src_a;
         assign b_next[gi]   = src_b;
         assign sum_next[gi] = sum_merged;
         assign c_next[gi]   = cv[BLOCK];
         assign v_next[gi]   = src_v;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            a_reg[k]   <= '0;
            b_reg[k]   <= '0;
            sum_reg[k] <= '0;
         end
         c_reg <= '0;
         v_reg <= '0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            a_reg[k]   <= a_next[k];
            b_reg[k]   <= b_next[k];
            sum_reg[k] <= sum_next[k];
         end
         c_reg <= c_next;
         v_reg <= v_next;
      end
   end

`ifdef PIPE_ADDER_OVF_EN
   // Signed overflow: the carry into the MSB differs from the carry out of it.
   // This is captured at the same time as the final stage, so it stays
   // aligned with result.
   logic ovf_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_reg <= 1'b0;
      end else if (advance) begin
         ovf_reg <= g_stage[STAGES-1].cv[BLOCK] ^ g_stage[STAGES-1].cv[BLOCK-1];
      end
   end

   assign ovf = ovf_reg;
`else
   assign ovf = 1'b0;
`endif

endmodule
